// File: rtl/cache2vias_wb_if.sv
// Processor load/store port and backing-memory port of the 2-way write-back cache.
// The slave modport is the cache's view; the master modport is the environment's view.
interface cache2vias_wb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_wren, req_addr, req_data, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_data, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wren, req_addr, req_data, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_data, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache2vias_wb.sv
// 2-way set-associative write-back / write-allocate cache, one-word lines, per-set LRU,
// with saturating hit/miss statistics.
module cache2vias_wb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    cache2vias_wb_if.slave   bus,
    output logic             hit,
    output logic             miss,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, DONE} state_t;
    state_t state, state_next;

    logic [1:0]        valid [SETS];
    logic [1:0]        dirty [SETS];
    logic [TAG_W-1:0]  tags  [SETS][2];
    logic [DATA_W-1:0] data  [SETS][2];
    logic [SETS-1:0]   lru;

    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              victim;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag_in;
    logic [1:0]         match;
    logic               any_hit;
    logic               hit_way;
    logic               pick;
    logic               pick_dirty;

    assign idx     = addr_q[INDEX_W-1:0];
    assign tag_in  = addr_q[ADDR_W-1:INDEX_W];
    assign match[0] = valid[idx][0] && (tags[idx][0] == tag_in);
    assign match[1] = valid[idx][1] && (tags[idx][1] == tag_in);
    assign any_hit = |match;
    assign hit_way = match[1];
    // Invalid ways are filled before the LRU way is ever evicted.
    assign pick       = !valid[idx][0] ? 1'b0 : (!valid[idx][1] ? 1'b1 : lru[idx]);
    assign pick_dirty = valid[idx][pick] && dirty[idx][pick];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.req_valid) state_next = COMPARE;
            COMPARE:   state_next = any_hit ? IDLE : (pick_dirty ? WRITEBACK : REFILL);
            WRITEBACK: if (bus.mem_ack) state_next = REFILL;
            REFILL:    if (bus.mem_ack) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        hit            = 1'b0;
        miss           = 1'b0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            COMPARE: begin
                hit            = any_hit;
                miss           = !any_hit;
                bus.resp_valid = any_hit;
                if (any_hit && !wren_q) bus.resp_data = data[idx][hit_way];
            end
            WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {tags[idx][victim], idx};
                bus.mem_wdata = data[idx][victim];
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                if (!wren_q) bus.resp_data = data[idx][victim];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid      <= '{default: '0};
            dirty      <= '{default: '0};
            lru        <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            victim     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wren_q  <= bus.req_wren;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_data;
                    end
                end
                COMPARE: begin
                    if (any_hit) begin
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        if (wren_q) begin
                            data[idx][hit_way]  <= wdata_q;
                            dirty[idx][hit_way] <= 1'b1;
                        end
                        lru[idx] <= ~hit_way;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        victim <= pick;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack) dirty[idx][victim] <= 1'b0;
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        valid[idx][victim] <= 1'b1;
                        tags[idx][victim]  <= tag_in;
                        data[idx][victim]  <= wren_q ? wdata_q : bus.mem_rdata;
                        dirty[idx][victim] <= wren_q;
                        lru[idx]           <= ~victim;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache2vias_wb.sv
// Self-checking bench for cache2vias_wb: recency-ordered line list model, per-cycle compare,
// directed scenarios plus randomized traffic.
module tb_cache2vias_wb;
    localparam int CMAX = 15;  // saturation value for CNT_W = 4

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hit, miss;
    logic [3:0] hit_count, miss_count;

    cache2vias_wb_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    cache2vias_wb #(.ADDR_W(8), .DATA_W(8), .INDEX_W(3), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .bus(bus), .hit(hit), .miss(miss),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a flat list of resident lines; recency is a timestamp, LRU = oldest in the set.
    typedef struct {
        logic [2:0] idx;
        logic [4:0] tag;
        logic [7:0] data;
        bit         dirty;
        int         stamp;
    } line_t;
    line_t mdl[$];
    int    now = 0;
    int    m_hits = 0, m_misses = 0;

    // Expected outputs for the current cycle, written by the driver, checked at negedge.
    bit         chk_en = 0;
    bit         e_ready, e_rv, e_hit, e_miss, e_mreq, e_mwe;
    logic [7:0] e_rdata, e_maddr, e_mwdata;

    logic [7:0] last_resp;
    bit         last_hit;
    logic [7:0] last_wb_addr, last_wb_data;
    bit         saw_mem;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(negedge clock) begin
        if (bus.resp_valid) last_resp = bus.resp_data;
        if (hit) last_hit = 1'b1;
        if (miss) last_hit = 1'b0;
        if (bus.mem_req) saw_mem = 1'b1;
        if (bus.mem_req && bus.mem_we) begin
            last_wb_addr = bus.mem_addr;
            last_wb_data = bus.mem_wdata;
        end
        if (chk_en) begin
            chk("req_ready", bus.req_ready, e_ready);
            chk("resp_valid", bus.resp_valid, e_rv);
            chk("hit", hit, e_hit);
            chk("miss", miss, e_miss);
            chk("mem_req", bus.mem_req, e_mreq);
            if (e_rv) chk("resp_data", bus.resp_data, e_rdata);
            if (e_mreq) begin
                chk("mem_we", bus.mem_we, e_mwe);
                chk("mem_addr", bus.mem_addr, e_maddr);
                if (e_mwe) chk("mem_wdata", bus.mem_wdata, e_mwdata);
            end
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_idle();
        e_ready = 1; e_rv = 0; e_hit = 0; e_miss = 0; e_mreq = 0; e_mwe = 0;
        e_rdata = 8'h00; e_maddr = 8'h00; e_mwdata = 8'h00;
    endtask

    task automatic exp_busy();
        exp_idle();
        e_ready = 0;
    endtask

    task automatic busy_noise();
        bus.req_valid = 1'($urandom);
        bus.req_wren  = 1'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        chk_en = 0;
        reset = 1;
        bus.req_valid = 0; bus.mem_ack = 0;
        tick(); tick();
        reset = 0;
        mdl.delete();
        m_hits = 0; m_misses = 0;
        exp_idle();
        chk_en = 1;
    endtask

    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input int wb_lat, input int rf_lat, input logic [7:0] rd);
        int         hi, cnt, lru_i;
        logic [2:0] ix;
        logic [4:0] tg;
        line_t      nl;
        ix = a[2:0];
        tg = a[7:3];
        hi = -1; cnt = 0; lru_i = -1;
        foreach (mdl[i]) begin
            if (mdl[i].idx == ix) begin
                cnt++;
                if (mdl[i].tag == tg) hi = i;
                if (lru_i < 0 || mdl[i].stamp < mdl[lru_i].stamp) lru_i = i;
            end
        end
        exp_idle();
        bus.req_valid = 1; bus.req_wren = wr; bus.req_addr = a; bus.req_data = wd;
        bus.mem_ack = 1'($urandom);
        tick();
        busy_noise();
        bus.mem_ack = 1'($urandom);
        now++;
        exp_busy();
        if (hi >= 0) begin
            e_hit = 1; e_rv = 1; e_rdata = wr ? 8'h00 : mdl[hi].data;
            tick();
            m_hits = sat(m_hits + 1);
            mdl[hi].stamp = now;
            if (wr) begin
                mdl[hi].data  = wd;
                mdl[hi].dirty = 1;
            end
        end else begin
            e_miss = 1;
            tick();
            m_misses = sat(m_misses + 1);
            exp_busy();
            if (cnt == 2) begin
                if (mdl[lru_i].dirty) begin
                    e_mreq = 1; e_mwe = 1;
                    e_maddr = {mdl[lru_i].tag, ix}; e_mwdata = mdl[lru_i].data;
                    for (int i = 0; i <= wb_lat; i++) begin
                        busy_noise();
                        bus.mem_ack = (i == wb_lat);
                        bus.mem_rdata = 8'($urandom);
                        tick();
                    end
                end
                mdl.delete(lru_i);
            end
            exp_busy();
            e_mreq = 1; e_mwe = 0; e_maddr = a;
            for (int i = 0; i <= rf_lat; i++) begin
                busy_noise();
                bus.mem_ack = (i == rf_lat);
                bus.mem_rdata = (i == rf_lat) ? rd : 8'($urandom);
                tick();
            end
            exp_busy();
            e_rv = 1; e_rdata = wr ? 8'h00 : rd;
            busy_noise();
            bus.mem_ack = 1'($urandom);
            tick();
            nl.idx = ix; nl.tag = tg; nl.data = wr ? wd : rd; nl.dirty = wr; nl.stamp = now;
            mdl.push_back(nl);
        end
        exp_idle();
        bus.req_valid = 0;
        bus.mem_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_wren = 0; bus.req_addr = '0; bus.req_data = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        exp_idle();
        tick();

        // Reset state and cold load / repeat load.
        do_reset();
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);
        do_req(0, 8'h13, 8'h00, 0, 3, 8'hA5);
        chk("t1_miss", last_hit, 0);
        chk("t1_refill_data", last_resp, 8'hA5);
        do_req(0, 8'h13, 8'h00, 0, 0, 8'h00);
        chk("t1_hit", last_hit, 1);
        chk("t1_hit_count", hit_count, 1);
        chk("t1_miss_count", miss_count, 1);

        // Store-allocate then load back without touching memory.
        do_req(1, 8'h21, 8'h5C, 0, 2, 8'hEE);
        saw_mem = 0;
        do_req(0, 8'h21, 8'h00, 0, 0, 8'h00);
        chk("t2_hit", last_hit, 1);
        chk("t2_data", last_resp, 8'h5C);
        chk("t2_no_mem", saw_mem, 0);

        // LRU: tag 3 is evicted after tag 2 is touched.
        do_reset();
        do_req(0, 8'h11, 8'h00, 0, 1, 8'h22);
        do_req(0, 8'h19, 8'h00, 0, 1, 8'h33);
        do_req(0, 8'h11, 8'h00, 0, 0, 8'h00);
        do_req(0, 8'h21, 8'h00, 0, 1, 8'h44);
        do_req(0, 8'h11, 8'h00, 0, 0, 8'h00);
        chk("t3_tag2_hits", last_hit, 1);
        chk("t3_tag2_data", last_resp, 8'h22);
        do_req(0, 8'h19, 8'h00, 0, 1, 8'h55);
        chk("t3_tag3_miss", last_hit, 0);

        // Dirty victim written back before the refill read.
        do_reset();
        do_req(1, 8'h09, 8'h77, 0, 1, 8'h00);
        do_req(0, 8'h11, 8'h00, 0, 1, 8'h12);
        do_req(0, 8'h19, 8'h00, 2, 1, 8'h34);
        chk("t4_wb_addr", last_wb_addr, 8'h09);
        chk("t4_wb_data", last_wb_data, 8'h77);

        // Reset while a refill is outstanding.
        do_req(0, 8'h13, 8'h00, 0, 0, 8'h3C);
        chk_en = 0;
        bus.req_valid = 1; bus.req_wren = 0; bus.req_addr = 8'h2B; bus.mem_ack = 0;
        tick();
        bus.req_valid = 0;
        tick(); tick(); tick();
        chk("t5_mem_req_before", bus.mem_req, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("t5_mem_req_after", bus.mem_req, 0);
        chk("t5_ready", bus.req_ready, 1);
        chk("t5_counts", {hit_count, miss_count}, 0);
        mdl.delete();
        m_hits = 0; m_misses = 0;
        exp_idle();
        chk_en = 1;
        do_req(0, 8'h13, 8'h00, 0, 0, 8'h61);
        chk("t5_line_dropped", last_hit, 0);
        do_req(0, 8'h09, 8'h00, 0, 0, 8'h62);
        chk("t5_line_dropped2", last_hit, 0);

        // Long memory stalls with stable outputs, then counter saturation.
        do_reset();
        do_req(1, 8'h0C, 8'h9A, 0, 0, 8'h00);
        do_req(1, 8'h14, 8'h9B, 0, 0, 8'h00);
        do_req(0, 8'h1C, 8'h00, 20, 20, 8'hC3);
        chk("t6_wb_addr", last_wb_addr, 8'h0C);
        chk("t6_resp", last_resp, 8'hC3);
        do_reset();
        for (int i = 0; i < 17; i++) do_req(0, 8'(i), 8'h00, 0, 0, 8'(i + 100));
        chk("t6_miss_sat", miss_count, CMAX);
        chk("t6_hit_zero", hit_count, 0);

        // Randomized traffic over a small tag range for a mix of hits, misses and writebacks.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            do_req(1'($urandom), {3'b000, 2'($urandom), 3'($urandom)}, 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
        end
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache2vias_wb.md
Name: cache2vias_wb

Overview:
Parametrised 2-way set-associative, write-back, write-allocate cache with one-word lines, per-set LRU replacement and dirty tracking. Sits between a simple processor load/store port and a slower backing memory with a req/ack handshake. Adds stall/ready signalling and hit/miss statistics counters.

Parameters:
ADDR_W, 8, word address width; tag width TAG_W = ADDR_W - INDEX_W
DATA_W, 8, data word width
INDEX_W, 3, set index width; SETS = 2**INDEX_W
CNT_W, 16, width of hit/miss statistics counters

Ports:
clock  in  1  single clock, all state changes on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  processor request present
req_wren  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address; index = [INDEX_W-1:0], tag = [ADDR_W-1:INDEX_W]
req_data  in  DATA_W  store data
req_ready  out  1  cache can accept a request this cycle
resp_valid  out  1  one-cycle pulse: request complete
resp_data  out  DATA_W  load data, valid with resp_valid (0 for stores)
hit  out  1  one-cycle pulse in COMPARE on tag match
miss  out  1  one-cycle pulse in COMPARE on no match
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = writeback, 0 = refill read
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  writeback data
mem_ack  in  1  memory completes transfer this cycle; mem_rdata valid when reading
mem_rdata  in  DATA_W  refill data
hit_count  out  CNT_W  saturating count of hits
miss_count  out  CNT_W  saturating count of misses

Behaviour:
- Storage per set per way: valid, dirty, tag, data; per set one LRU bit (= way to evict next).
- Reset: all valid, dirty, LRU bits cleared; state IDLE; all outputs 0 except req_ready = 1; counters 0. Reset mid-transfer aborts: mem_req low from the next cycle, no line updated, pending request dropped.
- FSM states: IDLE, COMPARE, WRITEBACK, REFILL, DONE.
- IDLE: req_ready = 1; on req_valid, latch wren/addr/data, go COMPARE. req_ready = 0 in all other states.
- COMPARE (one cycle after acceptance): way w hits if valid[w] and tag match; both ways never match simultaneously.
  - Hit: hit = 1, hit_count++; load returns data[w]; store writes data, sets dirty[w]; LRU <= ~w; resp_valid = 1 this cycle; next IDLE. Hit latency: response 1 cycle after acceptance.
  - Miss: miss = 1, miss_count++. Victim = way 0 if invalid, else way 1 if invalid, else LRU way. Victim valid and dirty -> WRITEBACK, else REFILL.
- WRITEBACK: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index}, mem_wdata = victim data, all stable until mem_ack; on mem_ack clear dirty, go REFILL.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = req_addr; on mem_ack install victim: valid = 1, tag = req tag. Load: data = mem_rdata, dirty = 0. Store: data = req_data, dirty = 1. LRU <= ~victim; go DONE.
- DONE: resp_valid = 1; resp_data = installed data for loads, 0 for stores; next IDLE.
- mem_req drops in the cycle after mem_ack. mem_ack outside WRITEBACK/REFILL is ignored.
- Counters saturate at 2**CNT_W - 1 and do not wrap.
- hit, miss, resp_valid are single-cycle pulses; each is 0 in every other state.

Test Plan:
1. Reset, then load addr 0x13 (mem_rdata = 0xA5, ack after 3 cycles) -> miss pulse, REFILL of 0x13, resp_data = 0xA5; repeat load -> hit, resp 1 cycle after accept, hit_count = 1, miss_count = 1.
2. Store 0x5C to 0x21 (miss, refill) then load 0x21 -> hit returns 0x5C; no mem_req on the load.
3. Same set (index 1), fill tags 0x02 and 0x03, touch tag 0x02, access tag 0x04 -> way holding tag 0x03 evicted; tag 0x02 still hits.
4. Dirty victim: store 0x77 to 0x09, fill set 1 with another tag, then miss on a third tag evicting 0x09 -> WRITEBACK with mem_we = 1, mem_addr = 0x09, mem_wdata = 0x77 before the refill read.
5. Assert reset while mem_req is high in REFILL -> mem_req = 0 next cycle, req_ready = 1, previously valid lines all miss, counters = 0.
6. Hold mem_ack low for 20 cycles -> mem_req, mem_addr and mem_wdata stable, req_ready = 0 throughout; with CNT_W = 2, 5 misses -> miss_count = 3.
